// File: rtl/firing_defs.sv
// Shared encodings for the firing dispatch FSM:
// firing modes, state encoding and result status codes.
package firing_defs;

    localparam logic [1:0] MODE_SETUP = 2'b00;
    localparam logic [1:0] MODE_INSTR = 2'b01;

    localparam int unsigned ST_OK      = 0;
    localparam int unsigned ST_ILLEGAL = 1;
    localparam int unsigned ST_TIMEOUT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_START,
        S_FETCH_WAIT,
        S_EXEC_START,
        S_EXEC_WAIT,
        S_OUTPUT,
        S_RST_INSTR,
        S_DONE
    } state_t;

endpackage

// File: rtl/dispatch_watchdog.sv
// Engine watchdog: counts enabled cycles and flags expiry in the
// cycle that would make the count reach the limit (0 disables).
module dispatch_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] r_count;
    logic [TMO_W:0]   w_inc;

    assign w_inc   = {1'b0, r_count} + (TMO_W+1)'(1);
    assign expired = en && (limit != '0) && (w_inc >= {1'b0, limit});

    // Cycle counter, held once expired so the flag stays asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= w_inc[TMO_W-1:0];
        end
    end

endmodule

// File: rtl/firing_dispatch_fsm.sv
// Firing dispatch FSM: fetches an opcode, starts the selected engine,
// forwards streamed and final results, and handles timeout/illegal ops.
module firing_dispatch_fsm
    import firing_defs::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int OPC_W     = 8,
    parameter int N_ENG     = 4,
    parameter int TMO_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [TMO_W-1:0]           tmo_limit,
    output logic                       fetch_start,
    input  logic                       fetch_done,
    input  logic [OPC_W-1:0]           fetch_opc,
    output logic [N_ENG-1:0]           eng_start,
    output logic [N_ENG-1:0]           eng_abort,
    input  logic [N_ENG-1:0]           eng_done,
    input  logic [N_ENG-1:0]           eng_out_valid,
    output logic                       eng_out_ready,
    input  logic [N_ENG*2*WORD_SIZE-1:0] eng_result,
    input  logic [N_ENG*2*WORD_SIZE-1:0] eng_status,
    input  logic                       out_full,
    output logic                       out_wr_en,
    output logic [2*WORD_SIZE-1:0]     out_result,
    output logic [2*WORD_SIZE-1:0]     out_status,
    output logic [OPC_W-1:0]           opc,
    output logic                       rst_instr,
    output logic                       busy,
    output logic                       done
);

    localparam int RW    = 2 * WORD_SIZE;
    localparam int IDX_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [OPC_W:0] ENG_LIM = (OPC_W+1)'(N_ENG);

    state_t r_state;
    state_t w_next;

    logic [OPC_W-1:0] r_opc;
    logic [RW-1:0]    r_out_result;
    logic [RW-1:0]    r_out_status;
    logic             r_done_seen;

    logic [N_ENG-1:0][RW-1:0] w_res_arr;
    logic [N_ENG-1:0][RW-1:0] w_sta_arr;
    logic [IDX_W-1:0] w_idx;
    logic [N_ENG-1:0] w_onehot;
    logic [RW-1:0]    w_res;
    logic [RW-1:0]    w_sta;
    logic w_in_range;
    logic w_rst_opc;
    logic w_done_any;
    logic w_pending;
    logic w_fin;
    logic w_expired;
    logic w_tmo;
    logic w_in_wait;

    assign w_res_arr  = eng_result;
    assign w_sta_arr  = eng_status;
    assign w_idx      = r_opc[IDX_W-1:0];
    assign w_onehot   = N_ENG'(1) << w_idx;
    assign w_res      = w_res_arr[w_idx];
    assign w_sta      = w_sta_arr[w_idx];
    assign w_in_range = {1'b0, r_opc} < ENG_LIM;
    assign w_rst_opc  = &r_opc;
    assign w_in_wait  = (r_state == S_EXEC_WAIT);

    // Done wins over timeout; a waiting stream item delays completion
    assign w_done_any = r_done_seen || eng_done[w_idx];
    assign w_pending  = eng_out_valid[w_idx];
    assign w_fin      = w_done_any && !w_pending;
    assign w_tmo      = w_expired && !w_done_any;

    dispatch_watchdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == S_EXEC_START),
        .en      (w_in_wait),
        .limit   (tmo_limit),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && mode == MODE_SETUP)      w_next = S_FETCH_START;
                else if (start && mode == MODE_INSTR) w_next = S_EXEC_START;
            end
            S_FETCH_START: w_next = S_FETCH_WAIT;
            S_FETCH_WAIT:  if (fetch_done) w_next = S_DONE;
            S_EXEC_START: begin
                if (w_in_range)     w_next = S_EXEC_WAIT;
                else if (w_rst_opc) w_next = S_RST_INSTR;
                else                w_next = S_OUTPUT;
            end
            S_EXEC_WAIT:   if (w_fin || w_tmo) w_next = S_OUTPUT;
            S_OUTPUT:      if (!out_full) w_next = S_DONE;
            S_RST_INSTR:   w_next = S_DONE;
            S_DONE:        w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    // Opcode, final result/status and done_seen bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opc        <= '0;
            r_out_result <= '0;
            r_out_status <= '0;
            r_done_seen  <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH_WAIT: begin
                    if (fetch_done) r_opc <= fetch_opc;
                end
                S_EXEC_START: begin
                    r_done_seen <= 1'b0;
                    if (!w_in_range && !w_rst_opc) begin
                        r_out_result <= '0;
                        r_out_status <= RW'(ST_ILLEGAL);
                    end
                end
                S_EXEC_WAIT: begin
                    if (eng_done[w_idx]) r_done_seen <= 1'b1;
                    if (w_fin) begin
                        r_out_result <= w_res;
                        r_out_status <= w_sta;
                    end else if (w_tmo) begin
                        r_out_result <= '0;
                        r_out_status <= RW'(ST_TIMEOUT);
                    end
                end
                S_RST_INSTR: r_opc <= '0;
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        fetch_start   = (r_state == S_FETCH_START);
        eng_start     = '0;
        eng_abort     = '0;
        eng_out_ready = w_in_wait && !out_full;
        out_wr_en     = 1'b0;
        out_result    = r_out_result;
        out_status    = r_out_status;
        rst_instr     = (r_state == S_RST_INSTR);
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        opc           = r_opc;
        if (r_state == S_EXEC_START && w_in_range) eng_start = w_onehot;
        if (w_in_wait) begin
            out_result = w_res;
            out_status = w_sta;
            out_wr_en  = w_pending && !out_full;
            if (w_tmo) eng_abort = w_onehot;
        end
        if (r_state == S_OUTPUT) out_wr_en = !out_full;
    end

endmodule
